// File: rtl/univ_shift_reg_if.sv
// Command/data bundle for the universal shift register: control and serial
// inputs from board I/O, register contents and status back to downstream logic.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             start_i;
  logic [2:0]       mode_i;
  logic [CNT_W-1:0] count_i;
  logic [WIDTH-1:0] d_i;
  logic             serial_r_i;
  logic             serial_l_i;
  logic [WIDTH-1:0] q_o;
  logic             ser_r_o;
  logic             ser_l_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, mode_i, count_i, d_i, serial_r_i, serial_l_i,
    input  q_o, ser_r_o, ser_l_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, count_i, d_i, serial_r_i, serial_l_i,
    output q_o, ser_r_o, ser_l_o, busy_o, done_o
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: a started command runs N shift/rotate steps (or a
// single hold/load/clear) paced by an internal prescaler, then pulses done.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int DIV   = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  univ_shift_reg_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_ROR   = 3'b011,
    M_ROL   = 3'b100,
    M_LOAD  = 3'b101,
    M_CLR   = 3'b110,
    M_HOLD2 = 3'b111
  } mode_t;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t           state, state_next;
  mode_t            mode_r, mode_next, mode_in;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] data_r, data_next;
  logic [CNT_W-1:0] steps, steps_next;
  logic [PW-1:0]    presc, presc_next;
  logic             tick;
  logic             in_shift;

  assign mode_in  = mode_t'(bus.mode_i);
  assign in_shift = (mode_in == M_SHR) || (mode_in == M_SHL) ||
                    (mode_in == M_ROR) || (mode_in == M_ROL);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      mode_r <= M_HOLD;
      q      <= '0;
      data_r <= '0;
      steps  <= '0;
      presc  <= '0;
    end else begin
      state  <= state_next;
      mode_r <= mode_next;
      q      <= q_next;
      data_r <= data_next;
      steps  <= steps_next;
      presc  <= presc_next;
    end
  end

  // Non-shift modes run a single tick, so their step count is forced to one.
  always_comb begin
    state_next = state;
    mode_next  = mode_r;
    data_next  = data_r;
    steps_next = steps;
    presc_next = presc;
    q_next     = q;
    tick       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          mode_next  = mode_in;
          data_next  = bus.d_i;
          presc_next = '0;
          steps_next = in_shift ? bus.count_i : CNT_W'(1);
          if (in_shift && (bus.count_i == '0)) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (presc == PRESC_LAST) begin
          presc_next = '0;
          tick       = 1'b1;
          steps_next = steps - CNT_W'(1);
          if (steps == CNT_W'(1)) begin
            state_next = DONE;
          end
        end else begin
          presc_next = presc + PW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Serial inputs are taken live on the tick edge rather than at start.
    if (tick) begin
      case (mode_r)
        M_SHR:   q_next = {bus.serial_r_i, q[WIDTH-1:1]};
        M_SHL:   q_next = {q[WIDTH-2:0], bus.serial_l_i};
        M_ROR:   q_next = {q[0], q[WIDTH-1:1]};
        M_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        M_LOAD:  q_next = data_r;
        M_CLR:   q_next = '0;
        default: q_next = q;
      endcase
    end
  end

  assign bus.q_o     = q;
  assign bus.ser_r_o = q[0];
  assign bus.ser_l_o = q[WIDTH-1];
  assign bus.busy_o  = (state == RUN);
  assign bus.done_o  = (state == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: one DUT at DIV=1 for the functional
// scenarios and a second at DIV=3 for prescaler pacing.
module tb_univ_shift_reg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] SHR  = 3'b001;
  localparam logic [2:0] SHL  = 3'b010;
  localparam logic [2:0] ROR  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] LOAD = 3'b101;
  localparam logic [2:0] CLR  = 3'b110;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  univ_shift_reg_if #(.WIDTH(4), .CNT_W(4)) b ();
  univ_shift_reg_if #(.WIDTH(4), .CNT_W(4)) b3 ();

  univ_shift_reg #(.WIDTH(4), .CNT_W(4), .DIV(1)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (b)
  );

  univ_shift_reg #(.WIDTH(4), .CNT_W(4), .DIV(3)) dut3 (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.start_i = 0;  b.mode_i = HOLD;  b.count_i = 0;  b.d_i = 0;
    b.serial_r_i = 0;  b.serial_l_i = 0;
    b3.start_i = 0; b3.mode_i = HOLD; b3.count_i = 0; b3.d_i = 0;
    b3.serial_r_i = 0; b3.serial_l_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.start_i = 1'($urandom);   b.mode_i = 3'($urandom);  b.count_i = 4'($urandom);
      b.d_i = 4'($urandom);       b.serial_r_i = 1'($urandom); b.serial_l_i = 1'($urandom);
      b3.start_i = 1'($urandom);  b3.mode_i = 3'($urandom); b3.count_i = 4'($urandom);
      b3.d_i = 4'($urandom);      b3.serial_r_i = 1'($urandom); b3.serial_l_i = 1'($urandom);
      step();
      checks++;
      if (b.q_o !== 4'b0000 || b.busy_o !== 1'b0 || b.done_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_dut: q=%b busy=%b done=%b expected q=0000 busy=0 done=0",
                 b.q_o, b.busy_o, b.done_o);
      end
    end
    checks++;
    if (b3.q_o !== 4'b0000 || b3.busy_o !== 1'b0 || b3.done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut3: q=%b busy=%b done=%b expected q=0000 busy=0 done=0",
               b3.q_o, b3.busy_o, b3.done_o);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    b.start_i = 1; b.mode_i = LOAD; b.d_i = 4'b1011; b.count_i = 4'd7;
    step();
    b.start_i = 0; b.d_i = 4'b0000;
    checks++;
    if (b.busy_o !== 1'b1 || b.q_o !== 4'b0000 || b.done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_accept: busy=%b q=%b done=%b expected busy=1 q=0000 done=0",
               b.busy_o, b.q_o, b.done_o);
    end
    step();
    checks++;
    if (b.q_o !== 4'b1011 || b.done_o !== 1'b1 || b.busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_result: q=%b done=%b busy=%b expected q=1011 done=1 busy=0",
               b.q_o, b.done_o, b.busy_o);
    end
    step();
    checks++;
    if (b.done_o !== 1'b0 || b.q_o !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL load_after: done=%b q=%b expected done=0 q=1011", b.done_o, b.q_o);
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_q [4];
    logic       ser   [4];
    exp_q[0] = 4'b1000; exp_q[1] = 4'b0100; exp_q[2] = 4'b1010; exp_q[3] = 4'b1101;
    ser[0] = 1; ser[1] = 0; ser[2] = 1; ser[3] = 1;
    b.start_i = 1; b.mode_i = CLR;
    step();
    b.start_i = 0;
    step();
    step();
    checks++;
    if (b.q_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clear: q=%b expected 0000", b.q_o);
    end
    b.start_i = 1; b.mode_i = SHR; b.count_i = 4'd4; b.serial_r_i = ser[0];
    step();
    b.start_i = 0;
    for (int i = 0; i < 4; i++) begin
      b.serial_r_i = ser[i];
      step();
      checks++;
      if (b.q_o !== exp_q[i] || b.ser_r_o !== exp_q[i][0] || b.ser_l_o !== exp_q[i][3]) begin
        errors++;
        $display("[TB] FAIL shr_step%0d: q=%b ser_r=%b ser_l=%b expected q=%b", i,
                 b.q_o, b.ser_r_o, b.ser_l_o, exp_q[i]);
      end
      checks++;
      if (b.done_o !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL shr_done%0d: done=%b expected %b", i, b.done_o, (i == 3));
      end
    end
    b.serial_r_i = 0;
    step();
  endtask

  task automatic test_rotate_left();
    int busy_cycles;
    bit done_seen;
    b.start_i = 1; b.mode_i = LOAD; b.d_i = 4'b1001;
    step();
    b.start_i = 0;
    step();
    step();
    b.start_i = 1; b.mode_i = ROL; b.count_i = 4'd5;
    step();
    b.start_i = 0;
    busy_cycles = 0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (b.busy_o) busy_cycles++;
      if (b.done_o) begin
        done_seen = 1;
        break;
      end
      b.start_i = (i == 1);
      b.mode_i  = (i == 1) ? CLR : ROL;
      step();
    end
    b.start_i = 0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("[TB] FAIL rol_timeout: done=0 after 20 cycles expected done=1");
    end
    checks++;
    if (b.q_o !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL rol_q: q=%b expected 0011", b.q_o);
    end
    checks++;
    if (busy_cycles != 5) begin
      errors++;
      $display("[TB] FAIL rol_busy: busy_cycles=%0d expected 5", busy_cycles);
    end
    step();
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_q [6];
    exp_q[0] = 4'b0000; exp_q[1] = 4'b0000; exp_q[2] = 4'b0001;
    exp_q[3] = 4'b0001; exp_q[4] = 4'b0001; exp_q[5] = 4'b0011;
    b3.start_i = 1; b3.mode_i = SHL; b3.count_i = 4'd2; b3.serial_l_i = 1;
    step();
    b3.start_i = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (b3.q_o !== exp_q[i] || b3.done_o !== (i == 5) || b3.busy_o !== (i != 5)) begin
        errors++;
        $display("[TB] FAIL div3_edge%0d: q=%b done=%b busy=%b expected q=%b done=%b busy=%b",
                 i + 1, b3.q_o, b3.done_o, b3.busy_o, exp_q[i], (i == 5), (i != 5));
      end
    end
    b3.serial_l_i = 0;
    step();
  endtask

  task automatic test_zero_count();
    b.start_i = 1; b.mode_i = SHR; b.count_i = 4'd0; b.serial_r_i = 1;
    step();
    b.start_i = 0;
    checks++;
    if (b.done_o !== 1'b1 || b.busy_o !== 1'b0 || b.q_o !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL zero_accept: done=%b busy=%b q=%b expected done=1 busy=0 q=0011",
               b.done_o, b.busy_o, b.q_o);
    end
    step();
    checks++;
    if (b.done_o !== 1'b0 || b.busy_o !== 1'b0 || b.q_o !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL zero_after: done=%b busy=%b q=%b expected done=0 busy=0 q=0011",
               b.done_o, b.busy_o, b.q_o);
    end
    b.serial_r_i = 0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    b.start_i = 1; b.mode_i = ROR; b.count_i = 4'd10;
    step();
    b.start_i = 0;
    step();
    step();
    checks++;
    if (b.q_o !== 4'b1100 || b.busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ror_midrun: q=%b busy=%b expected q=1100 busy=1", b.q_o, b.busy_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b.q_o !== 4'b0000 || b.busy_o !== 1'b0 || b.done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: q=%b busy=%b done=%b expected q=0000 busy=0 done=0",
               b.q_o, b.busy_o, b.done_o);
    end
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      if (b.done_o || b.busy_o) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL midrun_nodone: busy/done seen after reset expected none");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_load();
    test_shift_right();
    test_rotate_left();
    test_prescaler();
    test_zero_count();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Supports hold, shift right/left with serial inputs, rotate right/left, parallel load and clear.
- A command is issued with a start handshake. The block then performs N shift/rotate steps, paced by an internal prescaler, and reports completion with busy/done.
- Sits between board I/O (switches, serial line) and LED/downstream logic. The internal prescaler replaces the external frequency divider used with the fixed 4-bit register.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 4, width of step-count input; max steps = 2^CNT_W-1
DIV, 1, prescaler: one operation every DIV clocks while running (>=1)

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  command request, sampled in IDLE only
mode_i  input  3  000 hold, 001 shift right, 010 shift left, 011 rotate right, 100 rotate left, 101 parallel load, 110 clear, 111 hold
count_i  input  CNT_W  number of steps for shift/rotate modes
d_i  input  WIDTH  parallel load data
serial_r_i  input  1  bit entering MSB on shift right
serial_l_i  input  1  bit entering LSB on shift left
q_o  output  WIDTH  register contents
ser_r_o  output  1  q_o[0] (bit leaving on shift right)
ser_l_o  output  1  q_o[WIDTH-1] (bit leaving on shift left)
busy_o  output  1  high in RUN
done_o  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst_i=0, asynchronous):
  - q_o=0, state=IDLE, busy_o=0, done_o=0.
  - Prescaler and step counter cleared.
  - Reset mid-RUN aborts the command immediately; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start_i=1, latch mode_i, count_i and d_i, clear the prescaler, and go to RUN.
  - Exception: shift/rotate modes with count_i=0 go directly to DONE with q_o unchanged.
  - start_i=0: stay in IDLE, q_o holds.
- RUN:
  - Prescaler counts 0..DIV-1. Each time it wraps, one operation executes (tick).
  - Step counter decrements on every tick.
  - After the final tick, go to DONE.
  - Hold/load/clear modes execute exactly one tick regardless of count.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Timing: if start is accepted at edge k, operations occur at edges k+DIV, k+2·DIV, …, k+N·DIV. done_o is high in the cycle following edge k+N·DIV.
- Operations at a tick:
  - shift right: q <= {serial_r_i, q[WIDTH-1:1]}
  - shift left: q <= {q[WIDTH-2:0], serial_l_i}
  - rotate right: q <= {q[0], q[WIDTH-1:1]}
  - rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - load: q <= latched d
  - clear: q <= 0
  - hold: q unchanged
- Serial inputs are sampled live at each tick edge, not latched at start.
- start_i is ignored in RUN and DONE; no queuing. A new command can be accepted on the first IDLE cycle after DONE.
- busy_o=1 exactly while in RUN.
- ser_r_o and ser_l_o are driven directly from the register, with no extra latency.
- Changes to mode_i, count_i or d_i during RUN have no effect.

Test Plan:
- Reset (all cases WIDTH=4, DIV=1 unless noted): hold rst_i=0 with random inputs → q_o=0000, busy_o=0, done_o=0. Assert reset mid-RUN → q_o=0000 at once, no done pulse.
- Parallel load: start with mode=101, d_i=1011 → q_o=1011 one edge after acceptance. done_o pulses on the next cycle. busy_o high for 1 cycle.
- Shift right, 4 steps: serial_r_i sequence 1,0,1,1 → q_o progresses 1000, 0100, 1010, 1101. ser_r_o follows q_o[0]. done_o pulses after the 4th step.
- Rotate left, count=5, from q_o=1001 → final q_o=0011 (net rotate by 1). busy_o high for exactly 5 cycles. A start_i pulse during RUN is ignored.
- Prescaler with DIV=3: shift left, count=2, serial_l_i=1, from 0000 → q_o=0001 at edge k+3 and 0011 at edge k+6. q_o is unchanged on all other edges.
- Zero count: shift right with count_i=0 → no change to q_o, busy_o never asserted, done_o pulses the cycle after acceptance.
